fifo_dc_wr_arb: RTL and testbench

Write-domain controller for the dual-clock FIFO built on the generic dual-port RAM. It arbitrates two write requesters onto the single RAM write port using round-robin with valid/ready handshakes. It owns the binary and Gray write pointers and synchronises the read-domain Gray pointer. It generates full, almost-full and write-side occupancy, and exports the Gray write pointer to the read-side controller.

---
 rtl/fifo_dc_wr_arb.sv | 88 ++++++++
 tb/tb_fifo_dc_wr_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_dc_wr_arb.sv
// Write-side controller of the dual-clock FIFO: round-robin arbitration of two requesters onto the RAM write port.
// A word is written at the edge ending its accept cycle; ready is withheld (nothing is stored) when not granted or full.
module fifo_dc_wr_arb #(
  parameter int addr_width   = 8,
  parameter int data_width   = 8,
  parameter int afull_thresh = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  req0_valid,
  input  logic [data_width-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [data_width-1:0] req1_data,
  output logic                  req1_ready,
  input  logic [addr_width:0]   rptr_gray,
  output logic                  we,
  output logic [addr_width-1:0] waddr,
  output logic [data_width-1:0] di,
  output logic [addr_width:0]   wptr_gray,
  output logic                  full,
  output logic                  afull,
  output logic [addr_width:0]   wcount
);

  localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] athr  = (addr_width+1)'(afull_thresh);
  localparam logic [addr_width:0] one   = {{addr_width{1'b0}}, 1'b1};

  logic [addr_width:0] wbin;
  logic [addr_width:0] wbin_nxt;
  logic [addr_width:0] rsync1;
  logic [addr_width:0] rsync2;
  logic [addr_width:0] rbin_s;
  logic [addr_width:0] free;
  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic                accept;

  function automatic logic [addr_width:0] gray2bin(input logic [addr_width:0] g);
    logic [addr_width:0] b;
    b[addr_width] = g[addr_width];
    for (int i = addr_width - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Occupancy against the two-flop-delayed read pointer, so it can only overstate.
  assign rbin_s = gray2bin(rsync2);
  assign wcount = wbin - rbin_s;
  assign free   = depth - wcount;
  assign full   = ~wrst & (wcount == depth);
  assign afull  = ~wrst & (free <= athr);

  // last_grant=1 means req0 has priority on the next contended cycle.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0 & ~full & ~wrst;
  assign req1_ready = grant1 & ~full & ~wrst;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign we       = accept;
  assign waddr    = wbin[addr_width-1:0];
  assign di       = grant1 ? req1_data : req0_data;
  assign wbin_nxt = wbin + one;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin       <= '0;
      wptr_gray  <= '0;
      rsync1     <= '0;
      rsync2     <= '0;
      last_grant <= 1'b1;
    end else begin
      rsync1 <= rptr_gray;
      rsync2 <= rsync1;
      if (accept) begin
        wbin       <= wbin_nxt;
        wptr_gray  <= wbin_nxt ^ (wbin_nxt >> 1);
        last_grant <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_dc_wr_arb.sv
// Directed bench for fifo_dc_wr_arb: a depth-256 instance and a depth-4 instance sharing clock and reset.
module tb_fifo_dc_wr_arb;

  logic wclk;
  logic wrst;

  // depth-256 instance
  logic       v0, v1, r0, r1, we, full, afull;
  logic [7:0] d0, d1, waddr, di;
  logic [8:0] rg, wg, wcount;

  // depth-4 instance
  logic       bv0, bv1, br0, br1, bwe, bfull, bafull;
  logic [7:0] bd0, bd1, bdi;
  logic [1:0] bwaddr;
  logic [2:0] brg, bwg, bwcount;

  logic [2:0] gtab [8];
  int n_cmp;
  int n_err;

  fifo_dc_wr_arb #(.addr_width(8), .data_width(8), .afull_thresh(4)) dut (
    .wclk(wclk), .wrst(wrst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .rptr_gray(rg), .we(we), .waddr(waddr), .di(di), .wptr_gray(wg),
    .full(full), .afull(afull), .wcount(wcount)
  );

  fifo_dc_wr_arb #(.addr_width(2), .data_width(8), .afull_thresh(1)) dutb (
    .wclk(wclk), .wrst(wrst),
    .req0_valid(bv0), .req0_data(bd0), .req0_ready(br0),
    .req1_valid(bv1), .req1_data(bd1), .req1_ready(br1),
    .rptr_gray(brg), .we(bwe), .waddr(bwaddr), .di(bdi), .wptr_gray(bwg),
    .full(bfull), .afull(bafull), .wcount(bwcount)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int acc;
    int first_af;
    n_cmp = 0;
    n_err = 0;
    gtab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    v0 = 0; v1 = 0; d0 = 0; d1 = 0; rg = 0;
    bv0 = 0; bv1 = 0; bd0 = 0; bd1 = 0; brg = 0;
    wrst = 0;

    // reset state, with a requester already valid
    #1 wrst = 1; v0 = 1;
    #2;
    check("rst_ready0", 32'(r0), 0);
    check("rst_we", 32'(we), 0);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(afull), 0);
    check("rst_wcount", 32'(wcount), 0);
    check("rst_wptr", 32'(wg), 0);
    @(negedge wclk) wrst = 0; v0 = 0;

    // 1: three words from req0
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      v0 = 1; d0 = 8'(8'hA0 + k);
      #1;
      check("t1_we", 32'(we), 1);
      check("t1_waddr", 32'(waddr), 32'(k));
      check("t1_di", 32'(di), 32'(8'hA0 + k));
      check("t1_ready1", 32'(r1), 0);
    end
    @(negedge wclk) v0 = 0;
    #1;
    check("t1_wcount", 32'(wcount), 3);
    check("t1_wptr", 32'(wg), 32'b000000010);
    check("t1_idle_we", 32'(we), 0);

    // 2: both valid; req0 won last, so req1 leads the alternation
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      v0 = 1; v1 = 1; d0 = 8'(8'hB0 + k); d1 = 8'(8'hC0 + k);
      #1;
      check("t2_we", 32'(we), 1);
      check("t2_ready1", 32'(r1), (k % 2 == 0) ? 1 : 0);
      check("t2_ready0", 32'(r0), (k % 2 == 0) ? 0 : 1);
      check("t2_di", 32'(di), (k % 2 == 0) ? 32'(8'hC0 + k) : 32'(8'hB0 + k));
      check("t2_waddr", 32'(waddr), 32'(3 + k));
    end
    @(negedge wclk) v0 = 0; v1 = 0;
    #1 check("t2_wcount", 32'(wcount), 7);

    // 3: fill from empty
    @(negedge wclk) wrst = 1;
    #1 check("t3_rst_wcount", 32'(wcount), 0);
    @(negedge wclk) wrst = 0;
    acc = 0;
    first_af = -1;
    for (int i = 0; i < 256; i++) begin
      @(negedge wclk);
      v0 = 1; d0 = 8'(i);
      #1;
      if (we) acc++;
      if (afull && first_af < 0) first_af = int'(wcount);
    end
    check("t3_accepts", 32'(acc), 256);
    check("t3_afull_at", 32'(first_af), 252);
    @(negedge wclk);
    #1;
    check("t3_full", 32'(full), 1);
    check("t3_ready0", 32'(r0), 0);
    check("t3_we", 32'(we), 0);
    check("t3_waddr", 32'(waddr), 0);
    check("t3_wcount", 32'(wcount), 256);
    check("t3_wptr", 32'(wg), 32'h180);

    // 4: one read frees a slot after two sync edges
    rg = 9'h001;
    @(negedge wclk);
    #1 check("t4_full_e1", 32'(full), 1);
    @(negedge wclk) d0 = 8'hEE;
    #1;
    check("t4_full_e2", 32'(full), 0);
    check("t4_wcount", 32'(wcount), 255);
    check("t4_we", 32'(we), 1);
    check("t4_waddr", 32'(waddr), 0);
    check("t4_di", 32'(di), 32'hEE);
    @(negedge wclk) v0 = 0;
    #1;
    check("t4_refull", 32'(full), 1);
    check("t4_wcount2", 32'(wcount), 256);

    // 5: depth-4 instance, three fill/drain laps across the pointer MSB wrap
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge wclk);
        bv0 = 1; bd0 = 8'(l * 4 + k);
        #1;
        check("t5_we", 32'(bwe), 1);
        check("t5_waddr", 32'(bwaddr), 32'(k));
        check("t5_wptr", 32'(bwg), 32'(gtab[(l * 4 + k) % 8]));
        check("t5_full", 32'(bfull), 0);
        check("t5_afull", 32'(bafull), (k == 3) ? 1 : 0);
        check("t5_wcount", 32'(bwcount), 32'(k));
      end
      @(negedge wclk) bv0 = 0;
      #1;
      check("t5_full_lap", 32'(bfull), 1);
      check("t5_wcount_lap", 32'(bwcount), 4);
      for (int j = 0; j < 4; j++) begin
        @(negedge wclk) brg = gtab[(l * 4 + j + 1) % 8];
      end
      @(negedge wclk);
      @(negedge wclk);
      #1;
      check("t5_drained_cnt", 32'(bwcount), 0);
      check("t5_drained_full", 32'(bfull), 0);
      check("t5_drained_afull", 32'(bafull), 0);
    end
    check("t5_wptr_end", 32'(bwg), 32'(gtab[4]));

    // 6: asynchronous reset in the middle of an accept cycle
    @(negedge wclk) bv0 = 1; bd0 = 8'h5A;
    #1 check("t6_pre_we", 32'(bwe), 1);
    #1 wrst = 1; rg = 0; brg = 0;
    #1;
    check("t6_we", 32'(bwe), 0);
    check("t6_ready0", 32'(br0), 0);
    check("t6_wcount", 32'(bwcount), 0);
    check("t6_wptr", 32'(bwg), 0);
    check("t6_full", 32'(bfull), 0);
    check("t6_afull", 32'(bafull), 0);
    check("t6_main_full", 32'(full), 0);
    check("t6_main_wcount", 32'(wcount), 0);
    check("t6_main_wptr", 32'(wg), 0);
    @(negedge wclk) wrst = 0; bv1 = 1; bd1 = 8'h6B;
    #1;
    check("t6_post_ready0", 32'(br0), 1);
    check("t6_post_ready1", 32'(br1), 0);
    check("t6_post_waddr", 32'(bwaddr), 0);
    check("t6_post_di", 32'(bdi), 32'h5A);
    check("t6_post_we", 32'(bwe), 1);
    @(negedge wclk) bv0 = 0; bv1 = 0;
    #1 check("t6_post_wcount", 32'(bwcount), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
